// File: rtl/mac_to_axi_buffer.sv
// Single-frame store-and-forward buffer: captures one MAC RX frame into a word RAM
// and exposes the frame plus status registers through a read-only AXI4-Lite slave.
module mac_to_axi_buffer #(
  parameter int unsigned DEPTH_WORDS = 512
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] mac_rxd_i,
  input  logic [1:0]  mac_ben_i,
  input  logic        mac_rxda_i,
  input  logic        mac_rxsop_i,
  input  logic        mac_rxeop_i,
  input  logic        mac_rxdv_i,
  output logic        mac_rxrqrd_o,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DISCARD, S_READY} state_t;

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic          r_frame_ready;
  logic [15:0]   r_length;
  logic [15:0]   r_drop;
  logic          r_rxrqrd;
  logic          r_arready;
  logic          r_rvalid;
  logic          r_sel_ram;
  logic          r_is_release;
  logic [31:0]   r_rdata;
  logic [31:0]   r_ram_q;
  logic [1:0]    r_rresp;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_xfer;
  logic          w_we;
  logic          w_ptr_full;
  logic          w_sop_accept;
  logic [AW-1:0] w_waddr;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic [9:0]    w_ar_idx;
  logic          w_ar_inrange;
  logic [31:0]   w_status;

  always_comb begin
    w_xfer       = mac_rxdv_i & r_rxrqrd;
    w_ptr_full   = (r_ptr == PW'(DEPTH_WORDS));
    w_sop_accept = w_xfer & mac_rxsop_i & ((r_state == S_IDLE) | (r_state == S_CAPTURE));
    w_we         = w_sop_accept | (w_xfer & (r_state == S_CAPTURE) & ~w_ptr_full);
    w_waddr      = mac_rxsop_i ? '0 : r_ptr[AW-1:0];
    w_ar_hs      = S_AXI_ARVALID & r_arready;
    w_r_hs       = r_rvalid & S_AXI_RREADY;
    w_ar_idx     = S_AXI_ARADDR[11:2];
    w_ar_inrange = (32'(w_ar_idx) < DEPTH_WORDS);
    w_status     = {29'd0, mac_rxda_i,
                    (r_state == S_CAPTURE) | (r_state == S_DISCARD), r_frame_ready};
  end

  // Write and read share one edge, so a same-cycle read of the written word sees the old value.
  always_ff @(posedge ACLK) begin
    if (w_we)    r_mem[w_waddr] <= mac_rxd_i;
    if (w_ar_hs) r_ram_q        <= r_mem[w_ar_idx[AW-1:0]];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_frame_ready <= 1'b0;
      r_length      <= '0;
      r_drop        <= '0;
      r_rxrqrd      <= 1'b0;
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_sel_ram     <= 1'b0;
      r_is_release  <= 1'b0;
      r_rdata       <= '0;
      r_rresp       <= '0;
    end else begin
      r_rxrqrd <= (r_state != S_READY);

      if (w_ar_hs) begin
        r_arready    <= 1'b0;
        r_rvalid     <= 1'b1;
        r_sel_ram    <= 1'b0;
        r_is_release <= 1'b0;
        r_rdata      <= '0;
        r_rresp      <= 2'b00;
        if (S_AXI_ARADDR[12]) begin
          if (w_ar_inrange) r_sel_ram <= 1'b1;
          else              r_rresp   <= 2'b10;
        end else begin
          case (w_ar_idx)
            10'd0:   r_rdata <= w_status;
            10'd1:   r_rdata <= {16'd0, r_length};
            10'd2: begin
              r_rdata      <= w_status;
              r_is_release <= 1'b1;
            end
            10'd3:   r_rdata <= {16'd0, r_drop};
            default: r_rresp <= 2'b10;
          endcase
        end
      end else if (w_r_hs) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
        if (r_is_release) r_frame_ready <= 1'b0;
      end else if (!r_rvalid) begin
        r_arready <= 1'b1;
      end

      // SOP restarts the frame from IDLE or mid-capture; it takes priority over overflow.
      if (w_sop_accept) begin
        r_ptr <= PW'(1);
        if (mac_rxeop_i) begin
          r_length      <= 16'd4 - {14'd0, mac_ben_i};
          r_frame_ready <= 1'b1;
          r_rxrqrd      <= 1'b0;
          r_state       <= S_READY;
        end else begin
          r_state <= S_CAPTURE;
        end
      end else begin
        case (r_state)
          S_CAPTURE: if (w_xfer) begin
            if (w_ptr_full) begin
              if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
              r_state <= mac_rxeop_i ? S_IDLE : S_DISCARD;
            end else begin
              r_ptr <= r_ptr + PW'(1);
              if (mac_rxeop_i) begin
                r_length      <= ((16'(r_ptr) + 16'd1) << 2) - {14'd0, mac_ben_i};
                r_frame_ready <= 1'b1;
                r_rxrqrd      <= 1'b0;
                r_state       <= S_READY;
              end
            end
          end
          S_DISCARD: if (w_xfer && mac_rxeop_i) r_state <= S_IDLE;
          S_READY: if (!r_frame_ready) begin
            r_rxrqrd <= 1'b1;
            r_state  <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign mac_rxrqrd_o  = r_rxrqrd;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_sel_ram ? r_ram_q : r_rdata;

endmodule

// File: tb/tb_mac_to_axi_buffer.sv
// Directed bench for mac_to_axi_buffer: register/buffer reads from a vector table plus
// hand-written capture, overflow, release and reset sequences.
module tb_mac_to_axi_buffer;
  localparam int unsigned DEPTH = 512;
  localparam int TMO = 50;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] mac_rxd_i;
  logic [1:0]  mac_ben_i;
  logic        mac_rxda_i, mac_rxsop_i, mac_rxeop_i, mac_rxdv_i;
  logic        mac_rxrqrd_o;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID, S_AXI_RREADY;

  int n_total = 0;
  int n_pass  = 0;

  mac_to_axi_buffer #(.DEPTH_WORDS(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .mac_rxd_i(mac_rxd_i), .mac_ben_i(mac_ben_i), .mac_rxda_i(mac_rxda_i),
    .mac_rxsop_i(mac_rxsop_i), .mac_rxeop_i(mac_rxeop_i), .mac_rxdv_i(mac_rxdv_i),
    .mac_rxrqrd_o(mac_rxrqrd_o),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timeout after %0d cycles, expected handshake", name, TMO);
  endtask

  task automatic step;
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic sop, input logic eop,
                           input logic [1:0] ben);
    int n;
    n = 0;
    mac_rxd_i = d; mac_rxsop_i = sop; mac_rxeop_i = eop; mac_ben_i = ben; mac_rxdv_i = 1'b1;
    while (!mac_rxrqrd_o && n < TMO) begin step(); n++; end
    if (n >= TMO) timeout("rxrqrd_wait");
    step();
    mac_rxdv_i = 1'b0; mac_rxsop_i = 1'b0; mac_rxeop_i = 1'b0; mac_ben_i = 2'd0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < TMO) begin step(); n++; end
    if (n >= TMO) timeout("arready_wait");
    step();
    S_AXI_ARVALID = 1'b0;
    check("rvalid_after_ar", 32'(S_AXI_RVALID), 32'd1);
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    for (int k = 0; k < hold; k++) begin
      step();
      check("rdata_stable", S_AXI_RDATA, data);
      check("rvalid_held", 32'(S_AXI_RVALID), 32'd1);
    end
    S_AXI_RREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0;
    check("rvalid_after_r", 32'(S_AXI_RVALID), 32'd0);
    check("arready_after_r", 32'(S_AXI_ARREADY), 32'd1);
  endtask

  task automatic read_expect(input string name, input logic [31:0] addr,
                             input logic [31:0] exp_d, input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, 0, d, r);
    check({name, "_data"}, d, exp_d);
    check({name, "_resp"}, 32'(r), 32'(exp_r));
  endtask

  initial begin
    vec_t        vecs[10];
    logic [31:0] d;
    logic [1:0]  r;
    int          n;

    vecs[0] = '{addr: 32'h0000_0000, data: 32'h0000_0001, resp: 2'b00};
    vecs[1] = '{addr: 32'h0000_0004, data: 32'd62,        resp: 2'b00};
    vecs[2] = '{addr: 32'h0000_000C, data: 32'h0000_0000, resp: 2'b00};
    vecs[3] = '{addr: 32'h0000_1000, data: 32'h0001_0203, resp: 2'b00};
    vecs[4] = '{addr: 32'h0000_103C, data: 32'h0001_0212, resp: 2'b00};
    vecs[5] = '{addr: 32'h0000_0020, data: 32'h0000_0000, resp: 2'b10};
    vecs[6] = '{addr: 32'h0000_0010, data: 32'h0000_0000, resp: 2'b10};
    vecs[7] = '{addr: 32'h0000_1800, data: 32'h0000_0000, resp: 2'b10};
    vecs[8] = '{addr: 32'hFFFF_1002, data: 32'h0001_0203, resp: 2'b00};
    vecs[9] = '{addr: 32'h0000_1020, data: 32'h0001_020B, resp: 2'b00};

    ARESET = 1'b1;
    mac_rxd_i = '0; mac_ben_i = '0; mac_rxda_i = 1'b0;
    mac_rxsop_i = 1'b0; mac_rxeop_i = 1'b0; mac_rxdv_i = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    repeat (3) step();
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    check("rst_rxrqrd",  32'(mac_rxrqrd_o),  32'd0);
    ARESET = 1'b0;
    step();
    check("rel_arready", 32'(S_AXI_ARREADY), 32'd1);
    check("rel_rxrqrd",  32'(mac_rxrqrd_o),  32'd1);

    // Aborted start, then a 16-word frame whose SOP restarts capture at index 0.
    send_word(32'hDEAD_0000, 1'b1, 1'b0, 2'd0);
    send_word(32'hDEAD_0001, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 16; i++)
      send_word(32'h0001_0203 + 32'(i), i == 0, i == 15, (i == 15) ? 2'd2 : 2'd0);
    step();
    check("ready_rxrqrd", 32'(mac_rxrqrd_o), 32'd0);

    for (int i = 0; i < 10; i++)
      read_expect($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].resp);

    axi_read(32'h0000_1004, 3, d, r);
    check("hold_data", d, 32'h0001_0204);
    check("hold_resp", 32'(r), 32'd0);

    // Release: clears FRAME_READY on the R handshake, MAC re-enabled a cycle later.
    read_expect("release", 32'h0000_0008, 32'h0000_0001, 2'b00);
    check("rxrqrd_held_at_release", 32'(mac_rxrqrd_o), 32'd0);
    read_expect("status_after_rel", 32'h0000_0000, 32'h0000_0000, 2'b00);
    check("rxrqrd_after_rel", 32'(mac_rxrqrd_o), 32'd1);
    mac_rxda_i = 1'b1;
    read_expect("status_rxda", 32'h0000_0000, 32'h0000_0004, 2'b00);
    mac_rxda_i = 1'b0;

    // Oversized frame: first DEPTH words written, remainder dropped.
    for (int i = 0; i < int'(DEPTH) + 5; i++)
      send_word(32'hA000_0000 + 32'(i), i == 0, i == int'(DEPTH) + 4, 2'd0);
    step();
    read_expect("drop_count", 32'h0000_000C, 32'h0000_0001, 2'b00);
    read_expect("status_after_drop", 32'h0000_0000, 32'h0000_0000, 2'b00);
    check("rxrqrd_after_drop", 32'(mac_rxrqrd_o), 32'd1);

    send_word(32'hCAFE_BABE, 1'b1, 1'b1, 2'd0);
    step();
    read_expect("len_single", 32'h0000_0004, 32'd4, 2'b00);
    read_expect("status_single", 32'h0000_0000, 32'h0000_0001, 2'b00);
    read_expect("word0_single", 32'h0000_1000, 32'hCAFE_BABE, 2'b00);
    read_expect("stale_word1", 32'h0000_1004, 32'hA000_0001, 2'b00);
    read_expect("last_index", 32'h0000_17FC, 32'hA000_01FF, 2'b00);
    read_expect("release2", 32'h0000_0008, 32'h0000_0001, 2'b00);
    step();

    // Partial frame, then reset while a read response is pending.
    send_word(32'h1111_1111, 1'b1, 1'b0, 2'd0);
    send_word(32'h2222_2222, 1'b0, 1'b0, 2'd0);
    read_expect("status_capture", 32'h0000_0000, 32'h0000_0002, 2'b00);
    S_AXI_ARADDR = 32'h0000_000C; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < TMO) begin step(); n++; end
    if (n >= TMO) timeout("arready_wait_rst");
    step();
    S_AXI_ARVALID = 1'b0;
    check("rvalid_before_rst", 32'(S_AXI_RVALID), 32'd1);
    #2 ARESET = 1'b1;
    #1;
    check("midrst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    check("midrst_rxrqrd",  32'(mac_rxrqrd_o),  32'd0);
    check("midrst_arready", 32'(S_AXI_ARREADY), 32'd0);
    step();
    ARESET = 1'b0;
    step();
    read_expect("drop_after_rst", 32'h0000_000C, 32'h0000_0000, 2'b00);
    read_expect("status_after_rst", 32'h0000_0000, 32'h0000_0000, 2'b00);

    send_word(32'h0102_0304, 1'b1, 1'b0, 2'd0);
    send_word(32'h0506_0708, 1'b0, 1'b0, 2'd0);
    send_word(32'h090A_0B0C, 1'b0, 1'b1, 2'd1);
    step();
    read_expect("len_post_rst", 32'h0000_0004, 32'd11, 2'b00);
    read_expect("status_post_rst", 32'h0000_0000, 32'h0000_0001, 2'b00);
    read_expect("word2_post_rst", 32'h0000_1008, 32'h090A_0B0C, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
